// File: rtl/keypad_pkg.sv
// Shared types and elaboration helpers for the matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } kp_state_e;

  function automatic int code_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

  function automatic bit params_ok(input int rows, input int cols, input int scan_div,
                                   input int deb, input int rdel, input int rper);
    return (rows >= 2) && (rows <= 8) && (cols >= 2) && (cols <= 8) &&
           (scan_div >= 2) && (deb >= 1) && (rdel >= 1) && (rper >= 1);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level press/release debouncer; auto-repeat is built in when KEYPAD_REPEAT_EN is defined.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int KW              = 4,
  parameter int DEBOUNCE_FRAMES = 3
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 30,
  parameter int REPEAT_PERIOD   = 8
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_done,
  input  logic          hit,
  input  logic [KW-1:0] code,
  output logic [KW-1:0] key_code,
  output logic          key_valid,
  output logic          key_repeat,
  output logic          key_held,
  output logic          key_release
);

  localparam int CW = cnt_w(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] DF_C = CW'(DEBOUNCE_FRAMES);

  kp_state_e     state, state_n;
  logic [KW-1:0] cand, cand_n, code_n;
  logic [CW-1:0] cnt, cnt_n, rcnt, rcnt_n;
  logic          valid_n, held_n, release_n, repeat_n;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = cnt_w(RMAX);
  localparam logic [RW-1:0] RD_C = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RP_C = RW'(REPEAT_PERIOD);

  logic [RW-1:0] rep, rep_n;
  logic          armed, armed_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep   <= '0;
      armed <= 1'b0;
    end else begin
      rep   <= rep_n;
      armed <= armed_n;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cand        <= '0;
      cnt         <= '0;
      rcnt        <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_repeat  <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_n;
      cand        <= cand_n;
      cnt         <= cnt_n;
      rcnt        <= rcnt_n;
      key_code    <= code_n;
      key_valid   <= valid_n;
      key_repeat  <= repeat_n;
      key_held    <= held_n;
      key_release <= release_n;
    end
  end

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cnt_n     = cnt;
    rcnt_n    = rcnt;
    code_n    = key_code;
    held_n    = key_held;
    valid_n   = 1'b0;
    repeat_n  = 1'b0;
    release_n = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_n     = rep;
    armed_n   = armed;
`endif
    if (frame_done) begin
      unique case (state)
        ST_IDLE: begin
          if (hit) begin
            cand_n = code;
            cnt_n  = CW'(1);
            if (DF_C == CW'(1)) begin
              state_n = ST_PRESSED;
              valid_n = 1'b1;
              held_n  = 1'b1;
              code_n  = code;
              rcnt_n  = '0;
`ifdef KEYPAD_REPEAT_EN
              rep_n   = '0;
              armed_n = 1'b0;
`endif
            end else begin
              state_n = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (hit && code == cand) begin
            if (cnt + 1'b1 == DF_C) begin
              state_n = ST_PRESSED;
              valid_n = 1'b1;
              held_n  = 1'b1;
              code_n  = cand;
              rcnt_n  = '0;
`ifdef KEYPAD_REPEAT_EN
              rep_n   = '0;
              armed_n = 1'b0;
`endif
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else if (hit) begin
            cand_n = code;
            cnt_n  = CW'(1);
          end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
        ST_PRESSED: begin
          if (hit && code == key_code) begin
            rcnt_n = '0;
`ifdef KEYPAD_REPEAT_EN
            // First repeat after the long delay, then at the shorter period.
            if (rep + 1'b1 == (armed ? RP_C : RD_C)) begin
              valid_n  = 1'b1;
              repeat_n = 1'b1;
              rep_n    = '0;
              armed_n  = 1'b1;
            end else begin
              rep_n = rep + 1'b1;
            end
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            rep_n   = '0;
            armed_n = 1'b0;
`endif
            if (rcnt + 1'b1 == DF_C) begin
              state_n   = ST_IDLE;
              release_n = 1'b1;
              held_n    = 1'b0;
              rcnt_n    = '0;
              cnt_n     = '0;
            end else begin
              rcnt_n = rcnt + 1'b1;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad front end: column strobing, row synchronisation, per-frame priority encode.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int REPEAT_DELAY    = 30,
  parameter int REPEAT_PERIOD   = 8,
  localparam int KW             = code_w(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_repeat,
  output logic            key_held,
  output logic            key_release
);

  localparam int CIW = cnt_w(COLS - 1);
  localparam int DW  = cnt_w(SCAN_DIV - 1);

  if (!params_ok(ROWS, COLS, SCAN_DIV, DEBOUNCE_FRAMES, REPEAT_DELAY, REPEAT_PERIOD)) begin : g_param_check
    $error("keypad_scanner: illegal parameter set");
  end

  logic [ROWS-1:0] row_s1, row_s2;
  logic [CIW-1:0]  col_idx, col_p1, col_p2;
  logic [DW-1:0]   dwell;
  logic            last_dwell, last_col;
  logic            samp_p1, samp_p2, last_p1, last_p2;
  logic            col_hit, merge_hit, acc_hit;
  logic [KW-1:0]   col_code, merge_code, acc_code;
  logic            frame_done, frame_hit;
  logic [KW-1:0]   frame_code;

  // Lowest asserted row in the sampled column wins.
  function automatic logic [KW:0] encode_col(input logic [ROWS-1:0] rows_n,
                                             input logic [CIW-1:0] c);
    logic          h;
    logic [KW-1:0] k;
    h = 1'b0;
    k = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!rows_n[r]) begin
        h = 1'b1;
        k = KW'(r * COLS) + KW'(c);
      end
    end
    return {h, k};
  endfunction

  assign last_dwell = (dwell == DW'(SCAN_DIV - 1));
  assign last_col   = (col_idx == CIW'(COLS - 1));
  assign col        = ~(COLS'(1) << col_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell   <= '0;
      col_idx <= '0;
    end else if (last_dwell) begin
      dwell   <= '0;
      col_idx <= last_col ? '0 : col_idx + 1'b1;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  // Stages p1/p2: the sample point travels with the synchroniser so the row
  // value consumed belongs to the column that was driven when it was captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_p1 <= 1'b0;
      last_p1 <= 1'b0;
      samp_p2 <= 1'b0;
      last_p2 <= 1'b0;
    end else begin
      samp_p1 <= last_dwell;
      last_p1 <= last_dwell && last_col;
      samp_p2 <= samp_p1;
      last_p2 <= last_p1;
    end
  end

  always_ff @(posedge clk) begin
    col_p1 <= col_idx;
    col_p2 <= col_p1;
  end

  assign {col_hit, col_code} = encode_col(row_s2, col_p2);
  assign merge_hit  = acc_hit | col_hit;
  assign merge_code = (acc_hit && (!col_hit || acc_code <= col_code)) ? acc_code : col_code;

  // Frame accumulation: result latched and frame_done strobed after the last column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hit    <= 1'b0;
      frame_hit  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (samp_p2) begin
        if (last_p2) begin
          frame_done <= 1'b1;
          frame_hit  <= merge_hit;
          acc_hit    <= 1'b0;
        end else begin
          acc_hit <= merge_hit;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (samp_p2) begin
      if (last_p2) frame_code <= merge_code;
      else         acc_code   <= merge_code;
    end
  end

  keypad_debounce #(
    .KW              (KW),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
  ) u_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_done  (frame_done),
    .hit         (frame_hit),
    .code        (frame_code),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_repeat  (key_repeat),
    .key_held    (key_held),
    .key_release (key_release)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (4x4, dwell 4, 3-frame debounce) with a behavioural key matrix.
module tb_keypad_scanner;

  localparam int FR = 16;
`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_REP = 3;
`else
  localparam int EXP_REP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row, col;
  logic [3:0] key_code;
  logic       key_valid, key_repeat, key_held, key_release;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  int cyc;
  int n_valid = 0, n_release = 0, n_repeat = 0;
  int valid_cyc[$];

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          n_valid;
    int          n_release;
    int          held;
    int          code;
  } vec_t;

  vec_t tbl [25];

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(3),
    .REPEAT_DELAY(30), .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_repeat(key_repeat), .key_held(key_held),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid) begin
        n_valid++;
        valid_cyc.push_back(cyc);
      end
      if (key_release) n_release++;
      if (key_repeat)  n_repeat++;
      if (key_valid || key_release || key_repeat) begin
        checks++;
        if ((key_valid && key_release) || (key_repeat && !key_valid)) begin
          errors++;
          $display("FAIL pulse_excl at cyc %0d: valid=%0b repeat=%0b release=%0b",
                   cyc, key_valid, key_repeat, key_release);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_col"}, int'(col), 4'b1110);
    chk({tag, "_code"}, int'(key_code), 0);
    chk({tag, "_valid"}, int'(key_valid), 0);
    chk({tag, "_repeat"}, int'(key_repeat), 0);
    chk({tag, "_held"}, int'(key_held), 0);
    chk({tag, "_release"}, int'(key_release), 0);
  endtask

  task automatic check_phase(input int i, inout int pv, inout int pr);
    chk($sformatf("phase%0d_valid", i), n_valid - pv, tbl[i].n_valid);
    chk($sformatf("phase%0d_release", i), n_release - pr, tbl[i].n_release);
    chk($sformatf("phase%0d_held", i), int'(key_held), tbl[i].held);
    chk($sformatf("phase%0d_code", i), int'(key_code), tbl[i].code);
    pv = n_valid;
    pr = n_release;
  endtask

  initial begin
    int pv, pr, v0, r0, rp0, qb, t0;

    tbl[0]  = '{16'h0000, 2, 0, 0, 0, 0};
    tbl[1]  = '{16'h0040, 3, 1, 0, 1, 6};
    tbl[2]  = '{16'h0040, 2, 0, 0, 1, 6};
    tbl[3]  = '{16'h0000, 1, 0, 0, 1, 6};
    tbl[4]  = '{16'h0040, 1, 0, 0, 1, 6};
    tbl[5]  = '{16'h0000, 3, 0, 1, 0, 6};
    tbl[6]  = '{16'h0040, 1, 0, 0, 0, 6};
    tbl[7]  = '{16'h0000, 1, 0, 0, 0, 6};
    tbl[8]  = '{16'h0040, 1, 0, 0, 0, 6};
    tbl[9]  = '{16'h0000, 1, 0, 0, 0, 6};
    tbl[10] = '{16'h0040, 1, 0, 0, 0, 6};
    tbl[11] = '{16'h0000, 1, 0, 0, 0, 6};
    tbl[12] = '{16'h0040, 3, 1, 0, 1, 6};
    tbl[13] = '{16'h0000, 3, 0, 1, 0, 6};
    tbl[14] = '{16'h0210, 3, 1, 0, 1, 4};
    tbl[15] = '{16'h0200, 3, 0, 1, 0, 4};
    tbl[16] = '{16'h0200, 3, 1, 0, 1, 9};
    tbl[17] = '{16'h0000, 3, 0, 1, 0, 9};
    tbl[18] = '{16'h0020, 1, 0, 0, 0, 9};
    tbl[19] = '{16'h0008, 3, 1, 0, 1, 3};
    tbl[20] = '{16'h0000, 3, 0, 1, 0, 3};
    tbl[21] = '{16'h8004, 3, 1, 0, 1, 2};
    tbl[22] = '{16'h0000, 3, 0, 1, 0, 2};
    tbl[23] = '{16'h2020, 3, 1, 0, 1, 5};
    tbl[24] = '{16'h0000, 3, 0, 1, 0, 5};

    keys  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;

    // Phases start on frame boundaries; each is checked 4 cycles into the next.
    pv = n_valid;
    pr = n_release;
    for (int i = 0; i < 25; i++) begin
      keys = tbl[i].keys;
      if (i > 0) begin
        repeat (4) @(negedge clk);
        check_phase(i - 1, pv, pr);
        repeat (tbl[i].frames * FR - 4) @(negedge clk);
      end else begin
        repeat (tbl[i].frames * FR) @(negedge clk);
      end
    end
    keys = '0;
    repeat (4) @(negedge clk);
    check_phase(24, pv, pr);
    repeat (FR - 4) @(negedge clk);

    if (valid_cyc.size() > 0) chk("first_press_latency", valid_cyc[0], 83);
    else chk("first_press_seen", valid_cyc.size(), 1);

    // Reset while a key is held.
    keys = 16'h0040;
    repeat (3 * FR + 4) @(negedge clk);
    chk("pre_reset_held", int'(key_held), 1);
    repeat (5) @(negedge clk);
    r0 = n_release;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midpress");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v0 = n_valid;
    repeat (2 * FR + 4) @(negedge clk);
    chk("rereset_not_yet_held", int'(key_held), 0);
    repeat (FR) @(negedge clk);
    chk("rereset_held", int'(key_held), 1);
    chk("rereset_code", int'(key_code), 6);
    chk("rereset_valid_cnt", n_valid - v0, 1);
    chk("reset_no_release", n_release - r0, 0);
    repeat (FR - 4) @(negedge clk);
    keys = '0;
    repeat (3 * FR + 4) @(negedge clk);
    chk("rereset_release", n_release - r0, 1);
    chk("rereset_released", int'(key_held), 0);
    repeat (FR - 4) @(negedge clk);

    // Long hold of key 0: auto-repeat only in the repeat build.
    v0  = n_valid;
    r0  = n_release;
    rp0 = n_repeat;
    qb  = valid_cyc.size();
    t0  = cyc;
    keys = 16'h0001;
    repeat (53 * FR) @(negedge clk);
    keys = '0;
    repeat (4) @(negedge clk);
    chk("hold_held", int'(key_held), 1);
    chk("hold_code", int'(key_code), 0);
    repeat (3 * FR) @(negedge clk);
    chk("hold_valid_cnt", n_valid - v0, 1 + EXP_REP);
    chk("hold_repeat_cnt", n_repeat - rp0, EXP_REP);
    chk("hold_release_cnt", n_release - r0, 1);
    chk("hold_released", int'(key_held), 0);
    if (valid_cyc.size() > qb) chk("hold_press_latency", valid_cyc[qb] - t0, 51);
    else chk("hold_press_seen", valid_cyc.size() - qb, 1);
`ifdef KEYPAD_REPEAT_EN
    if (valid_cyc.size() >= qb + 4) begin
      chk("repeat_gap1", valid_cyc[qb+1] - valid_cyc[qb], 30 * FR);
      chk("repeat_gap2", valid_cyc[qb+2] - valid_cyc[qb+1], 8 * FR);
      chk("repeat_gap3", valid_cyc[qb+3] - valid_cyc[qb+2], 8 * FR);
    end else begin
      chk("repeat_entries", valid_cyc.size() - qb, 4);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
